// File: rtl/hazard_int_ctrl_pkg.sv
// Shared definitions for the hazard/interrupt sequencer.
// Holds the interrupt FSM state encoding, the register-field width and the
// $26 return-address register number used by the interrupt pseudo-instruction.
package hazard_int_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    // Register that receives the return PC on interrupt entry ($k0 / $26).
    localparam logic [REG_W-1:0] RET_REG = REG_W'(26);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_GUARD = 2'd2
    } int_state_e;

endpackage

// File: rtl/hazard_int_ctrl_irq_edge_sync.sv
// IRQ conditioning: optional two-flop synchroniser followed by a rising-edge
// detector producing a one-cycle pulse.
// Configuration macro: IRQ_SYNC_EN (defined -> synchroniser inserted).
// Ports:
//   CLK, Reset_n  : core clock, async active-low reset
//   irq           : raw interrupt request level
//   irq_rise_c    : combinational one-cycle pulse on a rising edge of irq_s
module hazard_int_ctrl_irq_edge_sync (
    input  logic CLK,
    input  logic Reset_n,
    input  logic irq,
    output logic irq_rise_c
);

    logic irq_s;
    logic irq_q;
    logic irq_d;

`ifdef IRQ_SYNC_EN
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    // Two-stage synchroniser for requests from asynchronous peripherals.
    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    // Previous-cycle copy for edge detection.
    assign irq_d = irq_s;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_rise_c = irq_s & ~irq_q;

endmodule

// File: rtl/hazard_int_ctrl.sv
// Pipeline hazard and interrupt sequencer for the 5-stage MIPS core.
// Detects load-use hazards, branch/jump redirects and external interrupts,
// and drives the IF/ID and ID/EX flush/protect controls plus PC enable.
// Hazard outputs are combinational from inputs and state (same-cycle).
// Configuration macro: IRQ_SYNC_EN (adds a two-flop IRQ synchroniser).
// Ports:
//   CLK, Reset_n            : core clock, async active-low reset
//   IRQ                     : level interrupt request
//   ID_rs, ID_rt, ID_UsesRt : ID-stage source registers / rt-read flag
//   ID_Jump, ID_Super       : ID jump, ID supervisor mode (masks interrupts)
//   EX_MemRd, EX_rt         : EX load and its destination
//   EX_BranchTaken          : branch resolved taken in EX
//   PC_Write, IF_Flush, IF_Protect, ID_Flush : pipeline controls
//   Int_Take, Int_Ack       : interrupt take / acknowledge (one cycle)
//   branchBeforeInter(2)    : return-PC adjust select on the take cycle
module hazard_int_ctrl
    import hazard_int_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             IRQ,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Jump,
    input  logic             ID_Super,
    input  logic             EX_MemRd,
    input  logic [REG_W-1:0] EX_rt,
    input  logic             EX_BranchTaken,
    output logic             PC_Write,
    output logic             IF_Flush,
    output logic             IF_Protect,
    output logic             ID_Flush,
    output logic             Int_Take,
    output logic             branchBeforeInter,
    output logic             branchBeforeInter2,
    output logic             Int_Ack
);

    int_state_e state_q;
    int_state_e state_d;
    logic       id_bubble_q;
    logic       id_bubble_d;
    logic       pend_next_q;
    logic       pend_next_d;
    logic       irq_rise_c;
    logic       load_use_c;
    logic       take_c;

    hazard_int_ctrl_irq_edge_sync u_irq_edge_sync (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .irq        (IRQ),
        .irq_rise_c (irq_rise_c)
    );

    // Load in EX whose destination feeds the ID instruction ($0 never hazards).
    assign load_use_c = EX_MemRd & (EX_rt != '0) &
                        ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));

    // Interrupt can only enter when ID is user code and nothing outranks it.
    assign take_c = (state_q == ST_PEND) & ~ID_Super & ~EX_BranchTaken & ~load_use_c;

    // ID holds a squashed slot next cycle whenever IF/ID is flushed now.
    assign id_bubble_d = IF_Flush;

    // State register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            id_bubble_q <= 1'b0;
            pend_next_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_bubble_q <= id_bubble_d;
            pend_next_q <= pend_next_d;
        end
    end

    // Next-state logic. A new edge during GUARD is remembered so it is not lost.
    always_comb begin
        state_d     = state_q;
        pend_next_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (irq_rise_c) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (take_c) state_d = ST_GUARD;
            end
            ST_GUARD: begin
                pend_next_d = pend_next_q | irq_rise_c;
                if (ID_Super) begin
                    state_d     = (pend_next_q | irq_rise_c) ? ST_PEND : ST_IDLE;
                    pend_next_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic in priority order: branch > take > load-use > jump > run.
    always_comb begin
        PC_Write           = 1'b1;
        IF_Flush           = 1'b0;
        IF_Protect         = 1'b0;
        ID_Flush           = 1'b0;
        Int_Take           = 1'b0;
        Int_Ack            = 1'b0;
        branchBeforeInter  = 1'b0;
        branchBeforeInter2 = 1'b0;
        if (EX_BranchTaken) begin
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
        end else if (take_c) begin
            Int_Take           = 1'b1;
            Int_Ack            = 1'b1;
            IF_Flush           = 1'b1;
            // A squashed ID slot has no valid PC; return via IF_PCplus4 instead.
            branchBeforeInter2 = id_bubble_q;
            branchBeforeInter  = ~id_bubble_q;
        end else if (load_use_c) begin
            PC_Write   = 1'b0;
            IF_Protect = 1'b1;
            ID_Flush   = 1'b1;
        end else if (ID_Jump) begin
            IF_Flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_int_ctrl.sv
// Self-checking bench for hazard_int_ctrl with a cycle-level behavioural model.
module tb_hazard_int_ctrl;

    logic       CLK = 1'b0;
    logic       Reset_n;
    logic       IRQ;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_UsesRt;
    logic       ID_Jump;
    logic       ID_Super;
    logic       EX_MemRd;
    logic [4:0] EX_rt;
    logic       EX_BranchTaken;
    logic       PC_Write;
    logic       IF_Flush;
    logic       IF_Protect;
    logic       ID_Flush;
    logic       Int_Take;
    logic       branchBeforeInter;
    logic       branchBeforeInter2;
    logic       Int_Ack;

    logic [7:0] obs;
    int         checks = 0;
    int         passes = 0;

    // Model state: request waiting, handler entered, request queued behind handler.
    bit m_pend;
    bit m_guard;
    bit m_queued;
    bit m_prev_flush;
    bit m_irq_prev;
    bit m_sync1;
    bit m_sync2;

    hazard_int_ctrl dut (
        .CLK                (CLK),
        .Reset_n            (Reset_n),
        .IRQ                (IRQ),
        .ID_rs              (ID_rs),
        .ID_rt              (ID_rt),
        .ID_UsesRt          (ID_UsesRt),
        .ID_Jump            (ID_Jump),
        .ID_Super           (ID_Super),
        .EX_MemRd           (EX_MemRd),
        .EX_rt              (EX_rt),
        .EX_BranchTaken     (EX_BranchTaken),
        .PC_Write           (PC_Write),
        .IF_Flush           (IF_Flush),
        .IF_Protect         (IF_Protect),
        .ID_Flush           (ID_Flush),
        .Int_Take           (Int_Take),
        .branchBeforeInter  (branchBeforeInter),
        .branchBeforeInter2 (branchBeforeInter2),
        .Int_Ack            (Int_Ack)
    );

    always #5 CLK = ~CLK;

    // Bit order: PC_Write IF_Flush IF_Protect ID_Flush Int_Take Int_Ack bBI bBI2
    assign obs = {PC_Write, IF_Flush, IF_Protect, ID_Flush,
                  Int_Take, Int_Ack, branchBeforeInter, branchBeforeInter2};

    function automatic bit m_irq_s();
`ifdef IRQ_SYNC_EN
        return m_sync2;
`else
        return IRQ;
`endif
    endfunction

    function automatic bit m_load_use();
        return EX_MemRd && (EX_rt != 5'd0) &&
               ((EX_rt == ID_rs) || (ID_UsesRt && (EX_rt == ID_rt)));
    endfunction

    function automatic logic [7:0] model_exp();
        if (EX_BranchTaken) return 8'b1101_0000;
        if (m_pend && !ID_Super && !m_load_use())
            return {6'b110011, ~m_prev_flush, m_prev_flush};
        if (m_load_use()) return 8'b0011_0000;
        if (ID_Jump) return 8'b1100_0000;
        return 8'b1000_0000;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_guard = 0; m_queued = 0; m_prev_flush = 0;
        m_irq_prev = 0; m_sync1 = 0; m_sync2 = 0;
    endtask

    task automatic model_advance();
        logic [7:0] e;
        bit rise;
        e = model_exp();
        rise = m_irq_s() && !m_irq_prev;
        if (m_guard) begin
            if (rise) m_queued = 1;
            if (ID_Super) begin
                m_guard = 0; m_pend = m_queued; m_queued = 0;
            end
        end else if (m_pend) begin
            if (e[3]) begin m_pend = 0; m_guard = 1; end
        end else if (rise) begin
            m_pend = 1;
        end
        m_prev_flush = e[6];
        m_irq_prev = m_irq_s();
        m_sync2 = m_sync1;
        m_sync1 = IRQ;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (Reset_n) model_advance(); else model_reset();
        #1;
    endtask

    task automatic idle_inputs();
        IRQ = 0; ID_rs = 0; ID_rt = 0; ID_UsesRt = 0; ID_Jump = 0;
        ID_Super = 0; EX_MemRd = 0; EX_rt = 0; EX_BranchTaken = 0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (obs !== 8'b1000_0000) $display("FAIL reset_hold: got %b want %b", obs, 8'b1000_0000);
        else passes++;
        tick();
        Reset_n = 1;
        @(negedge CLK);
        checks++;
        if (obs !== 8'b1000_0000) $display("FAIL reset_release: got %b want %b", obs, 8'b1000_0000);
        else passes++;
        tick();
    endtask

    task automatic test_load_use();
        logic [7:0] want [5];
        want = '{8'b0011_0000, 8'b1000_0000, 8'b1000_0000, 8'b1000_0000, 8'b0011_0000};
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            case (i)
                0: begin EX_MemRd = 1; EX_rt = 8; ID_rs = 8; end
                1: begin ID_rs = 8; end
                2: begin EX_MemRd = 1; EX_rt = 0; ID_rs = 0; end
                3: begin EX_MemRd = 1; EX_rt = 9; ID_rs = 3; ID_rt = 9; ID_UsesRt = 0; end
                default: begin EX_MemRd = 1; EX_rt = 9; ID_rs = 3; ID_rt = 9; ID_UsesRt = 1; end
            endcase
            @(negedge CLK);
            checks++;
            if (obs !== want[i]) $display("FAIL load_use_%0d: got %b want %b", i, obs, want[i]);
            else passes++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_branch_load();
        idle_inputs();
        EX_BranchTaken = 1; EX_MemRd = 1; EX_rt = 8; ID_rs = 8; ID_Jump = 1;
        @(negedge CLK);
        checks++;
        if (obs !== 8'b1101_0000) $display("FAIL branch_over_load: got %b want %b", obs, 8'b1101_0000);
        else passes++;
        tick();
        idle_inputs();
        ID_Jump = 1;
        @(negedge CLK);
        checks++;
        if (obs !== 8'b1100_0000) $display("FAIL jump_alone: got %b want %b", obs, 8'b1100_0000);
        else passes++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_irq_pulse();
        logic [7:0] e;
        logic [7:0] tv;
        int takes;
        takes = 0; tv = '0;
        idle_inputs();
        IRQ = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            e = model_exp();
            checks++;
            if (obs !== e) $display("FAIL irq_pulse_c%0d: got %b want %b", i, obs, e);
            else passes++;
            if (Int_Take) begin takes++; tv = obs; end
            tick();
            IRQ = 0;
        end
        checks++;
        if (takes != 1) $display("FAIL irq_pulse_count: got %0d want 1", takes);
        else passes++;
        checks++;
        if (tv !== 8'b1100_1110) $display("FAIL irq_pulse_take_vec: got %b want %b", tv, 8'b1100_1110);
        else passes++;
        takes = 0;
        for (int i = 0; i < 5; i++) begin
            ID_Super = (i == 0);
            @(negedge CLK);
            e = model_exp();
            checks++;
            if (obs !== e) $display("FAIL irq_guard_exit_c%0d: got %b want %b", i, obs, e);
            else passes++;
            if (Int_Take) takes++;
            tick();
        end
        checks++;
        if (takes != 0) $display("FAIL irq_no_retake: got %0d want 0", takes);
        else passes++;
        idle_inputs();
    endtask

    task automatic test_jump_irq();
        logic [7:0] e;
        logic [7:0] tv;
        int takes;
        takes = 0; tv = '0;
        idle_inputs();
        ID_Jump = 1; IRQ = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            e = model_exp();
            checks++;
            if (obs !== e) $display("FAIL jump_irq_c%0d: got %b want %b", i, obs, e);
            else passes++;
            if (Int_Take) begin takes++; tv = obs; end
            tick();
            IRQ = 0;
        end
        checks++;
        if (takes != 1) $display("FAIL jump_irq_count: got %0d want 1", takes);
        else passes++;
        checks++;
        if (tv !== 8'b1100_1101) $display("FAIL jump_irq_take_vec: got %b want %b", tv, 8'b1100_1101);
        else passes++;
        idle_inputs();
        ID_Super = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_super_hold();
        logic [7:0] e;
        int takes;
        takes = 0;
        idle_inputs();
        ID_Super = 1; IRQ = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            e = model_exp();
            checks++;
            if (obs !== e) $display("FAIL super_hold_c%0d: got %b want %b", i, obs, e);
            else passes++;
            if (Int_Take) takes++;
            tick();
        end
        checks++;
        if (takes != 0) $display("FAIL super_hold_count: got %0d want 0", takes);
        else passes++;
        ID_Super = 0;
        @(negedge CLK);
        checks++;
        if (Int_Take !== 1'b1) $display("FAIL super_release_take: got %b want 1", Int_Take);
        else passes++;
        tick();
        takes = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (Int_Take) takes++;
            tick();
        end
        checks++;
        if (takes != 0) $display("FAIL super_level_no_retrigger: got %0d want 0", takes);
        else passes++;
        IRQ = 0; ID_Super = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        int takes;
        idle_inputs();
        ID_Super = 1; IRQ = 1;
        repeat (4) tick();
        IRQ = 0;
        tick();
        @(negedge CLK);
        Reset_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== 8'b1000_0000) $display("FAIL reset_mid_outputs: got %b want %b", obs, 8'b1000_0000);
        else passes++;
        tick();
        Reset_n = 1;
        ID_Super = 0;
        takes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            e = model_exp();
            checks++;
            if (obs !== e) $display("FAIL reset_mid_after_c%0d: got %b want %b", i, obs, e);
            else passes++;
            if (Int_Take) takes++;
            tick();
        end
        checks++;
        if (takes != 0) $display("FAIL reset_mid_dropped: got %0d want 0", takes);
        else passes++;
        IRQ = 1;
        takes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (Int_Take) takes++;
            tick();
            IRQ = 0;
        end
        checks++;
        if (takes != 1) $display("FAIL reset_mid_new_edge: got %0d want 1", takes);
        else passes++;
        ID_Super = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_guard_retrigger();
        logic [7:0] e;
        int takes;
        takes = 0;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            IRQ = (i == 0) || (i == 6);
            ID_Super = (i == 11);
            @(negedge CLK);
            e = model_exp();
            checks++;
            if (obs !== e) $display("FAIL guard_retrigger_c%0d: got %b want %b", i, obs, e);
            else passes++;
            if (Int_Take) takes++;
            tick();
        end
        checks++;
        if (takes != 2) $display("FAIL guard_retrigger_count: got %0d want 2", takes);
        else passes++;
        idle_inputs();
        ID_Super = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5, 0) == 0) IRQ = ~IRQ;
            if ($urandom_range(7, 0) == 0) ID_Super = ~ID_Super;
            EX_BranchTaken = ($urandom_range(7, 0) == 0);
            EX_MemRd       = ($urandom_range(2, 0) == 0);
            ID_Jump        = ($urandom_range(5, 0) == 0);
            ID_UsesRt      = 1'($urandom_range(1, 0));
            EX_rt          = 5'($urandom_range(3, 0));
            ID_rs          = 5'($urandom_range(3, 0));
            ID_rt          = 5'($urandom_range(3, 0));
            @(negedge CLK);
            e = model_exp();
            checks++;
            if (obs !== e) $display("FAIL random_c%0d: got %b want %b", i, obs, e);
            else passes++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        Reset_n = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_load_use();
        test_branch_load();
        test_irq_pulse();
        test_jump_irq();
        test_super_hold();
        test_reset_mid();
        test_guard_retrigger();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
